// File: rtl/freq_gen.sv
// -----------------------------------------------------------------------------
// freq_gen
//   Programmable square-wave generator, the transmit-side partner of the
//   frequency meter. A load captures a 4-digit BCD frequency in kHz units
//   (d1 = MHz place ... d4 = kHz place). A short sequential datapath then
//   computes the half-period in clock cycles:
//     CONV  : 4 cycles, BCD -> binary kHz value, MSD first
//     SCALE : 1 cycle,  den = 2000 * kHz   (= 2 * F_HZ)
//     DIV   : CNT_W cycles, restoring divide CLK_HZ / den
//     APPLY : 1 cycle,  install the new half-period and restart the phase
//   A toggle counter turns the half-period into a 50% duty square wave.
//   The previous waveform keeps running for the whole reprogram.
//
// Ports
//   clk     in   system clock, CLK_HZ
//   rst     in   asynchronous reset, active-high
//   load    in   1-cycle strobe: capture digit1..digit4, start a reprogram
//   digit1  in   BCD, 1 MHz place
//   digit2  in   BCD, 100 kHz place
//   digit3  in   BCD, 10 kHz place
//   digit4  in   BCD, 1 kHz place
//   signal  out  generated square wave (registered)
//   busy    out  reprogram in progress, loads ignored while high
//   err     out  last accepted-in-IDLE load held a digit above 9
// -----------------------------------------------------------------------------
module freq_gen #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  output logic       signal,
  output logic       busy,
  output logic       err
);

  localparam int unsigned STEP_W = $clog2(CNT_W) + 1;
  localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_HZ);
  localparam logic [STEP_W-1:0] LAST_DIGIT = STEP_W'(3);
  localparam logic [STEP_W-1:0] LAST_DIV_STEP = STEP_W'(CNT_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SCALE,
    DIV,
    APPLY
  } state_t;

  state_t               state_q, state_d;
  logic [3:0][3:0]      digits_q, digits_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [CNT_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     den_q, den_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]     dvd_q, dvd_d;
  logic [CNT_W-1:0]     quo_q, quo_d;
  logic [CNT_W-1:0]     half_q, half_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 signal_q, signal_d;
  logic                 err_q, err_d;

  logic                 digitsBad;
  logic [3:0]           curDigit;
  logic [CNT_W:0]       remShift;
  logic [CNT_W-1:0]     remDiff;

  // A digit above 9 makes the whole load invalid.
  assign digitsBad = (digit1 > 4'd9) || (digit2 > 4'd9) ||
                     (digit3 > 4'd9) || (digit4 > 4'd9);

  // Digit consumed by the current CONV step; slot 0 holds the MSD.
  assign curDigit = digits_q[step_q[1:0]];

  // One restoring-divide step: bring down the next dividend bit, then try
  // to subtract the denominator. remDiff is only used when remShift >= den,
  // so the modular CNT_W-bit subtraction is exact there.
  assign remShift = {rem_q, dvd_q[CNT_W-1]};
  assign remDiff  = remShift[CNT_W-1:0] - den_q;

  // State and datapath registers. Reset abandons any reprogram in flight and
  // stops the waveform.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      den_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      half_q   <= '0;
      cnt_q    <= '0;
      signal_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      den_q    <= den_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      quo_q    <= quo_d;
      half_q   <= half_d;
      cnt_q    <= cnt_d;
      signal_q <= signal_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: the reprogram sequencer plus the free-running toggle
  // counter. The toggle counter runs in every state; only APPLY overrides it.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    step_d   = step_q;
    acc_d    = acc_q;
    den_d    = den_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    half_d   = half_q;
    cnt_d    = cnt_q;
    signal_d = signal_q;
    err_d    = err_q;

    // Toggle counter: half==0 means stopped with the output parked low.
    if (half_q == '0) begin
      cnt_d    = '0;
      signal_d = 1'b0;
    end else if (cnt_q == half_q - CNT_W'(1)) begin
      cnt_d    = '0;
      signal_d = ~signal_q;
    end else begin
      cnt_d    = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (load) begin
          if (digitsBad) begin
            err_d = 1'b1;
          end else begin
            err_d       = 1'b0;
            digits_d[0] = digit1;
            digits_d[1] = digit2;
            digits_d[2] = digit3;
            digits_d[3] = digit4;
            acc_d       = '0;
            step_d      = '0;
            state_d     = CONV;
          end
        end
      end

      CONV: begin
        // acc*10 + digit, with the multiply done as (acc<<3)+(acc<<1).
        acc_d = (acc_q << 3) + (acc_q << 1) + CNT_W'(curDigit);
        if (step_q == LAST_DIGIT) begin
          state_d = SCALE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      SCALE: begin
        // 2000 = 1024 + 512 + 256 + 128 + 64 + 16
        den_d = (acc_q << 10) + (acc_q << 9) + (acc_q << 8) +
                (acc_q << 7) + (acc_q << 6) + (acc_q << 4);
        rem_d = '0;
        dvd_d = DIVIDEND;
        quo_d = '0;
        step_d = '0;
        // An all-zero frequency has no divide to do; go straight to APPLY
        // with a zero quotient, which stops the waveform.
        if (acc_q == '0) begin
          state_d = APPLY;
        end else begin
          state_d = DIV;
        end
      end

      DIV: begin
        dvd_d = dvd_q << 1;
        if (remShift >= {1'b0, den_q}) begin
          rem_d = remDiff;
          quo_d = {quo_q[CNT_W-2:0], 1'b1};
        end else begin
          rem_d = remShift[CNT_W-1:0];
          quo_d = {quo_q[CNT_W-2:0], 1'b0};
        end
        if (step_q == LAST_DIV_STEP) begin
          state_d = APPLY;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      APPLY: begin
        // Restart the phase so the new waveform begins with a full high half.
        half_d   = quo_q;
        cnt_d    = '0;
        signal_d = (quo_q != '0);
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign signal = signal_q;
  assign busy   = (state_q != IDLE);
  assign err    = err_q;

endmodule
